// File: rtl/mem_port_arbiter.sv
// Shared memory port sequencer/arbiter for fetch and load/store requesters.
// Define MEM_ARB_RR_EN for alternating priority on conflicts; default is data-first.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_done,
  input  logic                  dm_req,
  input  logic                  dm_wr_en,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic                  stall
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t state;
  logic   decide;
  logic   if_pend;
  logic   dm_pend;
  logic   pick_dm;
  logic   pick_if;

  assign if_done  = (state == GNT_I) & mem_ack;
  assign dm_done  = (state == GNT_D) & mem_ack;
  assign if_rdata = if_done ? mem_rdata : '0;
  assign dm_rdata = dm_done ? mem_rdata : '0;
  assign stall    = (if_req & ~if_done) | (dm_req & ~dm_done);

  // The requester finishing this cycle is masked so its held req is not re-granted.
  assign decide  = (state == IDLE) | mem_ack;
  assign if_pend = if_req & (state != GNT_I);
  assign dm_pend = dm_req & (state != GNT_D);

`ifdef MEM_ARB_RR_EN
  logic last_dm;

  assign pick_dm = dm_pend & (~if_pend | ~last_dm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dm <= 1'b0;
    end else if (decide) begin
      if (pick_dm) begin
        last_dm <= 1'b1;
      end else if (pick_if) begin
        last_dm <= 1'b0;
      end
    end
  end
`else
  assign pick_dm = dm_pend;
`endif

  assign pick_if = if_pend & ~pick_dm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (decide) begin
      if (pick_dm) begin
        state     <= GNT_D;
        mem_req   <= 1'b1;
        mem_we    <= dm_wr_en;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (pick_if) begin
        state     <= GNT_I;
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
      end else begin
        state     <= IDLE;
        mem_req   <= 1'b0;
        mem_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester tasks queue expected accesses,
// a negedge monitor checks every done pulse against them.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_wr_en;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [31:0] if_rdata, dm_rdata;
  logic        if_done, dm_done;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ws = 0;
  int wcnt = 0;
  bit force_ack = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q_if[$];
  exp_t q_dm[$];

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory data: 0x100 holds the addi instruction, everything else is addr ^ A5A50000.
  function automatic logic [31:0] rd_fn(logic [31:0] a);
    return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
  endfunction

  // Memory responder with ws wait states per access.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        if (wcnt == ws) begin
          mem_ack = 1'b1;
          mem_rdata = rd_fn(mem_addr);
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = 32'h0;
          wcnt++;
        end
      end else begin
        mem_ack = force_ack;
        mem_rdata = force_ack ? 32'h1234_5678 : 32'h0;
        wcnt = 0;
      end
    end
  end

  // Monitor: pop and compare on every done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("dual_done", {31'b0, if_done & dm_done}, 32'h0);
        if (if_done) begin
          if (q_if.size() == 0) begin
            chk("if_unexpected_done", 32'h1, 32'h0);
          end else begin
            e = q_if.pop_front();
            chk("if_addr", mem_addr, e.addr);
            chk("if_we", {31'b0, mem_we}, 32'h0);
            chk("if_rdata", if_rdata, e.rdata);
            chk("if_done_cycle", cyc, e.cyc);
          end
        end else if (mem_req) begin
          chk("if_rdata_idle", if_rdata, 32'h0);
        end
        if (dm_done) begin
          if (q_dm.size() == 0) begin
            chk("dm_unexpected_done", 32'h1, 32'h0);
          end else begin
            e = q_dm.pop_front();
            chk("dm_addr", mem_addr, e.addr);
            chk("dm_we", {31'b0, mem_we}, {31'b0, e.we});
            if (e.we) chk("dm_wdata", mem_wdata, e.wdata);
            chk("dm_rdata", dm_rdata, e.rdata);
            chk("dm_done_cycle", cyc, e.cyc);
          end
        end else if (mem_req) begin
          chk("dm_rdata_idle", dm_rdata, 32'h0);
        end
      end
    end
  end

  // Called just after a rising edge; raises req, waits for done, drops req.
  task automatic issue(input bit is_dm, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
    exp_t e;
    bit got;
    e.addr = addr; e.we = is_dm & we; e.wdata = wdata; e.rdata = rdata; e.cyc = cyc + lat;
    if (is_dm) begin
      q_dm.push_back(e);
      dm_req = 1'b1; dm_wr_en = we; dm_addr = addr; dm_wdata = wdata;
    end else begin
      q_if.push_back(e);
      if_req = 1'b1; if_addr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = is_dm ? dm_done : if_done;
    end
    chk(is_dm ? "dm_timeout" : "if_timeout", {31'b0, got}, 32'h1);
    @(posedge clk);
    #1;
    if (is_dm) dm_req = 1'b0;
    else if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_dm;
    int lat_if;
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b0; dm_wr_en = 1'b0; dm_addr = '0; dm_wdata = '0;

    // Reset held with a pending fetch
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_if_done", {31'b0, if_done}, 32'h0);
    chk("rst_dm_done", {31'b0, dm_done}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h1);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(0, 0, 32'h40, 32'h0, 32'hA5A5_0040, 1);

    // Single fetch, zero wait states
    issue(0, 0, 32'h100, 32'h0, 32'h0050_0093, 1);

    // Store with two wait states
    ws = 2;
    fork
      issue(1, 1, 32'h2000, 32'hDEAD_BEEF, 32'hA5A5_2000, 3);
      begin
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("st_mem_req", {31'b0, mem_req}, 32'h1);
          chk("st_mem_we", {31'b0, mem_we}, 32'h1);
          chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
          chk("st_dm_done", {31'b0, dm_done}, (i == 2) ? 32'h1 : 32'h0);
          chk("st_stall", {31'b0, stall}, (i == 2) ? 32'h0 : 32'h1);
        end
      end
    join

    // Two conflicts, one wait state each; second grant follows the ack directly
`ifdef MEM_ARB_RR_EN
    lat_dm = 4; lat_if = 2;
`else
    lat_dm = 2; lat_if = 4;
`endif
    ws = 1;
    fork
      issue(1, 0, 32'h300, 32'h0, 32'hA5A5_0300, lat_dm);
      issue(0, 0, 32'h400, 32'h0, 32'hA5A5_0400, lat_if);
    join
    fork
      issue(1, 1, 32'h500, 32'h1111_2222, 32'hA5A5_0500, lat_dm);
      issue(0, 0, 32'h600, 32'h0, 32'hA5A5_0600, lat_if);
    join

    // Reset in the middle of a data access
    ws = 3;
    @(posedge clk);
    #1;
    dm_req = 1'b1; dm_wr_en = 1'b0; dm_addr = 32'h700;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_req_before", {31'b0, mem_req}, 32'h1);
    chk("mid_mem_addr_before", mem_addr, 32'h700);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_mem_req_after", {31'b0, mem_req}, 32'h0);
    chk("mid_dm_done", {31'b0, dm_done}, 32'h0);
    chk("mid_mem_addr_after", mem_addr, 32'h0);
    dm_req = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_idle_mem_req", {31'b0, mem_req}, 32'h0);

    // Stray ack while idle
    ws = 0;
    @(posedge clk);
    #1;
    force_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_ack_mem_req", {31'b0, mem_req}, 32'h0);
      chk("idle_ack_if_done", {31'b0, if_done}, 32'h0);
      chk("idle_ack_dm_done", {31'b0, dm_done}, 32'h0);
      chk("idle_ack_dm_rdata", dm_rdata, 32'h0);
    end
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    issue(0, 0, 32'h800, 32'h0, 32'hA5A5_0800, 1);

    repeat (3) @(negedge clk);
    chk("q_if_empty", q_if.size(), 32'h0);
    chk("q_dm_empty", q_dm.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for a single shared memory port used by the instruction-fetch path and the load/store path. It lets the core run from one unified memory. Each requester holds a request until it receives a one-cycle done pulse. The block grants one access at a time, drives the shared port from latched request fields, and raises a stall toward the pipeline while any request is outstanding. It sits between the IF/MEM stages and the memory, and is driven by the decoded mem_wr_en / load controls.

## Interface
- ADDR_WIDTH, 32, byte address width of both requesters and memory
- DATA_WIDTH, 32, data width of both requesters and memory

Ports (reset is asynchronous, active-low):
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held high until if_done
- if_addr  in  ADDR_WIDTH  fetch address; stable while if_req high
- if_rdata  out  DATA_WIDTH  fetch data; valid only while if_done high
- if_done  out  1  fetch access complete (one-cycle pulse)
- dm_req  in  1  load/store request; held high until dm_done
- dm_wr_en  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_rdata  out  DATA_WIDTH  load data; valid only while dm_done high
- dm_done  out  1  data access complete (one-cycle pulse)
- mem_req  out  1  access in progress on shared port
- mem_we  out  1  write strobe to memory
- mem_addr  out  ADDR_WIDTH  latched address
- mem_wdata  out  DATA_WIDTH  latched write data
- mem_rdata  in  DATA_WIDTH  read data; valid while mem_ack high
- mem_ack  in  1  memory completes the current access; may be high in the first mem_req cycle
- stall  out  1  (if_req & ~if_done) | (dm_req & ~dm_done)

## Operation
- FSM states: IDLE, GNT_I, GNT_D. Reset state is IDLE.
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Latched grant fields are 0.
- Grant decision happens in IDLE, and in GNT_x during a cycle with mem_ack=1.
- Fixed priority (default): dm_req beats if_req.
- On a grant, the following are registered from the granted requester: address; write data (data port only); we (dm_wr_en for data, 0 for fetch). The FSM moves to GNT_D or GNT_I.
- In GNT_x: mem_req=1 and the mem_* outputs come from the registers.
- When mem_ack=1 in GNT_x:
  - x_done=1 combinationally, and x_rdata = mem_rdata (pass-through).
  - The next state is decided with the finished requester's req masked for that cycle. Go to the other requester's grant if it is pending, else IDLE.
- A requester seeing x_done must either drop x_req the next cycle or present a new request. req high in the cycle after done is treated as a new access.
- mem_ack is ignored in IDLE.
- Outside the done cycle, if_rdata and dm_rdata are 0.
- A requester that drops req before done violates the protocol. The in-flight access still completes and its done is still pulsed.
- Asserting rst_n low mid-access forces IDLE and mem_req=0 immediately (asynchronous). The in-flight access is abandoned, and the memory must tolerate this.

## Timing
- Minimum latency: req rises in cycle 0 (IDLE), grant registered at edge 1, mem_req high in cycle 1. With mem_ack in cycle 1, done is in cycle 1 (1-cycle latency).
- Memory wait states add one cycle each.
- Back-to-back grants have no idle cycle: the ack cycle of one access is followed directly by mem_req of the next.
- A lone requester issuing consecutive accesses sees one access per 2 cycles (IDLE cycle in between).
- stall is purely combinational from req/done. There is no registered path.

## Configuration
- MEM_ARB_RR_EN defined:
  - A last_grant register (reset = I) selects between simultaneous requests: the requester not granted last wins.
  - The first conflict after reset goes to data.
  - Neither port starves.
- MEM_ARB_RR_EN undefined:
  - No last_grant register; data always wins.
  - Fetch can starve under continuous dm traffic, which is accepted because the pipeline stalls fetch anyway.

## Test plan
- Reset: rst_n=0 with if_req=1 -> mem_req=0, all done=0, stall=1. After release, GNT_I, mem_addr=if_addr.
- Single fetch: if_addr=0x100, memory acks in the first mem_req cycle with mem_rdata=0x00500093 -> if_done=1 in cycle 1, if_rdata=0x00500093, mem_we=0.
- Store with 2 wait states: dm_wr_en=1, dm_addr=0x2000, dm_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF held for 3 cycles. dm_done pulses only in the ack cycle.
- Simultaneous if_req and dm_req in IDLE:
  - default build: dm granted first; the fetch is granted in the cycle after the dm ack, with no gap.
  - MEM_ARB_RR_EN: the next conflict goes to fetch.
- Reset mid-access: assert rst_n=0 during GNT_D before mem_ack -> mem_req drops in the same cycle, dm_done never pulses, state IDLE.
- Protocol check: mem_ack pulsed while IDLE -> no done asserted, state unchanged, mem_req stays 0.
